video_pattern_src: RTL and testbench
====================================

VIDEO_PATTERN_SRC -- requirements
Module: video_pattern_src

Interface
REQ-001 Parameter H_ACTIVE, 1280: active pixels per line.
REQ-002 Parameters H_FP 110, H_SYNC 40, H_BP 220: horizontal porch and sync lengths in clocks; H_TOTAL is their sum plus H_ACTIVE.
REQ-003 Parameters V_ACTIVE 720, V_FP 5, V_SYNC 5, V_BP 20: vertical lengths in lines; V_TOTAL is their sum.
REQ-004 Parameter SYNC_POL, 1: asserted level of ycbcr_hs and ycbcr_vs.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  run request.
REQ-008 pattern_sel  in  2  pattern: 0 horizontal ramp, 1 vertical ramp, 2 checkerboard, 3 box outline.
REQ-009 ycbcr_vs  out  1  vertical sync.
REQ-010 ycbcr_hs  out  1  horizontal sync.
REQ-011 ycbcr_de  out  1  active-pixel enable.
REQ-012 ycbcr_y  out  8  luma pixel.
REQ-013 pix_x  out  11  active column, valid when ycbcr_de is high.
REQ-014 pix_y  out  11  active row, valid when ycbcr_de is high.
REQ-015 frame_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-016 FSM states:
- IDLE: enable=1 -> RUN, with h_cnt=0 and v_cnt=0 on the next cycle.
- RUN: at the last count (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1), enable=0 -> IDLE.
REQ-017 In RUN, h_cnt counts 0..H_TOTAL-1 and wraps to 0; v_cnt increments on each h_cnt wrap and wraps to 0 after V_TOTAL-1.
REQ-018 Sync regions:
- hs is asserted for h_cnt in [0, H_SYNC).
- vs is asserted for v_cnt in [0, V_SYNC).
REQ-019 Active region:
- de is high when h_cnt is in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
- pix_x and pix_y are the offsets into those ranges.
REQ-020 All outputs are registered and share one cycle of latency from the counters, so sync, de, pixel and coordinates stay mutually aligned.
REQ-021 Pattern values (ycbcr_y):
- 0: pix_x[7:0].
- 1: pix_y[7:0].
- 2: 8'hFF when pix_x[3] xor pix_y[3] is 1, else 8'h00.
- 3: 8'hFF on row 0, row V_ACTIVE-1, column 0 and column H_ACTIVE-1; 8'h00 elsewhere.
REQ-022 ycbcr_y is 8'h00 whenever ycbcr_de is low.
REQ-023 pattern_sel is latched only at h_cnt=0, v_cnt=0; a change mid-frame takes effect at the next frame.
REQ-024 If enable falls mid-frame, the current frame completes; the block then goes to IDLE with hs/vs deasserted and de=0.
REQ-025 frame_done pulses for one cycle, aligned with the output of the last count (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1).
REQ-026 If enable is held high, frames run back-to-back with no idle cycle.
REQ-027 Counter widths are 12 bits; parameter sums must fit in 12 bits.

Reset
REQ-028 While rst_n is low:
- state is IDLE and counters are 0.
- ycbcr_hs and ycbcr_vs sit at the deasserted level (!SYNC_POL).
- de, ycbcr_y, pix_x, pix_y and frame_done are 0.
REQ-029 Reset asserted mid-frame takes effect immediately; after release, a new frame starts only from h_cnt=0, v_cnt=0.

Structure
REQ-030 Package video_pkg holds:
- the pattern-select constants (PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_BOX);
- the 720p default timing constants;
- the FSM state typedef.
REQ-031 Sub-module test_pattern_pix is the combinational pixel function (pattern, pix_x, pix_y, de -> y); the counters and FSM stay in the top module.

Verification
Bench settings: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7).
REQ-032 Reset then enable=1, pattern 0 -> per line:
- hs high for 2 cycles;
- de high for exactly 8 cycles;
- ycbcr_y runs 0..7;
- 4 de lines per frame;
- frame_done period is 98 cycles.
REQ-033 Pattern 3 -> row 0 and row 3 all 8'hFF; rows 1-2 are FF,00,00,00,00,00,00,FF.
REQ-034 Change pattern_sel 0->2 in the middle of frame 1 -> frame 1 stays a ramp; frame 2 is a checkerboard.
REQ-035 Drop enable at line 2 of a frame -> the frame finishes, frame_done pulses once, and the outputs go idle with no further de.
REQ-036 Assert rst_n low during an active line -> de, ycbcr_y and frame_done are 0 in the same cycle; after release with enable=1, the first hs starts at a frame boundary.

Source files
------------

// File: rtl/video_pattern_src_pkg.sv
// rtl/video_pattern_src_pkg.sv - shared constants and types for the video pattern source
//
// Package video_pkg:
//   CNT_W / PIX_W          counter and coordinate widths
//   PAT_*                  pattern-select codes
//   *_720P                 default 1280x720 timing
//   state_t, ST_*          FSM state type and encodings
package video_pkg;

    localparam int CNT_W = 12;
    localparam int PIX_W = 11;

    localparam logic [1:0] PAT_HRAMP = 2'd0;
    localparam logic [1:0] PAT_VRAMP = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_BOX   = 2'd3;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/video_pattern_src_if.sv
// rtl/video_pattern_src_if.sv - control inputs and video outputs of the pattern source
//
// master: the pattern source (drives video, receives enable/pattern_sel)
// slave : the video sink / controller
interface video_pattern_src_if;
    import video_pkg::*;

    logic             enable;
    logic [1:0]       pattern_sel;
    logic             ycbcr_vs;
    logic             ycbcr_hs;
    logic             ycbcr_de;
    logic [7:0]       ycbcr_y;
    logic [PIX_W-1:0] pix_x;
    logic [PIX_W-1:0] pix_y;
    logic             frame_done;

    modport master (
        input  enable, pattern_sel,
        output ycbcr_vs, ycbcr_hs, ycbcr_de, ycbcr_y, pix_x, pix_y, frame_done
    );

    modport slave (
        output enable, pattern_sel,
        input  ycbcr_vs, ycbcr_hs, ycbcr_de, ycbcr_y, pix_x, pix_y, frame_done
    );

endinterface

// File: rtl/test_pattern_pix.sv
// rtl/test_pattern_pix.sv - combinational luma value for one pixel of the selected pattern
//
// Ports:
//   i_pattern  2      pattern code (PAT_*)
//   i_pix_x    PIX_W  active column
//   i_pix_y    PIX_W  active row
//   i_de       1      active-pixel enable; luma is forced to 0 when low
//   o_y        8      luma
module test_pattern_pix
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P
) (
    input  logic [1:0]       i_pattern,
    input  logic [PIX_W-1:0] i_pix_x,
    input  logic [PIX_W-1:0] i_pix_y,
    input  logic             i_de,
    output logic [7:0]       o_y
);

    localparam logic [PIX_W-1:0] X_LAST = PIX_W'(H_ACTIVE - 1);
    localparam logic [PIX_W-1:0] Y_LAST = PIX_W'(V_ACTIVE - 1);

    logic w_border;

    assign w_border = (i_pix_x == '0) || (i_pix_x == X_LAST) ||
                      (i_pix_y == '0) || (i_pix_y == Y_LAST);

    always_comb begin
        o_y = 8'h00;
        if (i_de) begin
            case (i_pattern)
                PAT_HRAMP: o_y = i_pix_x[7:0];
                PAT_VRAMP: o_y = i_pix_y[7:0];
                PAT_CHECK: o_y = (i_pix_x[3] ^ i_pix_y[3]) ? 8'hFF : 8'h00;
                PAT_BOX:   o_y = w_border ? 8'hFF : 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/video_pattern_src.sv
// rtl/video_pattern_src.sv - raster timing generator with selectable luma test patterns
//
// Ports:
//   clk    1   rising-edge clock
//   rst_n  1   asynchronous active-low reset
//   vid    video_pattern_src_if.master: enable, pattern_sel in;
//          ycbcr_vs/hs/de/y, pix_x, pix_y, frame_done out (all registered)
module video_pattern_src
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P,
    parameter int SYNC_POL = 1
) (
    input  logic clk,
    input  logic rst_n,
    video_pattern_src_if.master vid
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYN_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYN_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_BEG = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_BEG = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic             SYNC_ON   = 1'(SYNC_POL);

    state_t           r_state;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic [1:0]       r_pat;

    logic             w_run;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_hs;
    logic             w_vs;
    logic             w_de;
    logic [PIX_W-1:0] w_pix_x;
    logic [PIX_W-1:0] w_pix_y;
    logic [7:0]       w_y;

    assign w_run    = (r_state == ST_RUN);
    assign w_h_last = (r_h_cnt == H_LAST);
    assign w_v_last = (r_v_cnt == V_LAST);

    // Counters only advance in RUN; IDLE holds them at 0 so the first RUN
    // cycle is always the frame origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run) begin
            if (vid.enable) begin
                r_state <= ST_RUN;
            end
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            if (w_v_last) begin
                r_v_cnt <= '0;
                if (!vid.enable) begin
                    r_state <= ST_IDLE;
                end
            end else begin
                r_v_cnt <= r_v_cnt + CNT_W'(1);
            end
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    // Pattern is sampled at the frame origin, which is in blanking, so the
    // new value is in place before the first active pixel of the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat <= PAT_HRAMP;
        end else if (w_run && (r_h_cnt == '0) && (r_v_cnt == '0)) begin
            r_pat <= vid.pattern_sel;
        end
    end

    assign w_hs    = w_run && (r_h_cnt < H_SYN_END);
    assign w_vs    = w_run && (r_v_cnt < V_SYN_END);
    assign w_de    = w_run && (r_h_cnt >= H_ACT_BEG) && (r_h_cnt < H_ACT_END) &&
                     (r_v_cnt >= V_ACT_BEG) && (r_v_cnt < V_ACT_END);
    assign w_pix_x = w_de ? PIX_W'(r_h_cnt - H_ACT_BEG) : '0;
    assign w_pix_y = w_de ? PIX_W'(r_v_cnt - V_ACT_BEG) : '0;

    test_pattern_pix #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_pix (
        .i_pattern (r_pat),
        .i_pix_x   (w_pix_x),
        .i_pix_y   (w_pix_y),
        .i_de      (w_de),
        .o_y       (w_y)
    );

    // Single register stage for every output keeps sync, de, luma and
    // coordinates aligned to the same counter value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid.ycbcr_hs   <= ~SYNC_ON;
            vid.ycbcr_vs   <= ~SYNC_ON;
            vid.ycbcr_de   <= 1'b0;
            vid.ycbcr_y    <= 8'h00;
            vid.pix_x      <= '0;
            vid.pix_y      <= '0;
            vid.frame_done <= 1'b0;
        end else begin
            vid.ycbcr_hs   <= w_hs ? SYNC_ON : ~SYNC_ON;
            vid.ycbcr_vs   <= w_vs ? SYNC_ON : ~SYNC_ON;
            vid.ycbcr_de   <= w_de;
            vid.ycbcr_y    <= w_y;
            vid.pix_x      <= w_pix_x;
            vid.pix_y      <= w_pix_y;
            vid.frame_done <= w_run && w_h_last && w_v_last;
        end
    end

endmodule

// File: tb/tb_video_pattern_src.sv
// tb/tb_video_pattern_src.sv - scoreboard testbench for video_pattern_src
`timescale 1ns/1ps
module tb_video_pattern_src;
    import video_pkg::*;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    video_pattern_src_if vif();

    video_pattern_src #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vid   (vif)
    );

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  v;
    } pix_t;

    pix_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   fd_count = 0;

    // Hand-computed interior row of the 8-wide box outline.
    logic [7:0] box_mid [8] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [1:0] pat);
        pix_t p;
        for (int r = 0; r < VA; r++) begin
            for (int c = 0; c < HA; c++) begin
                p.x = 11'(c);
                p.y = 11'(r);
                case (pat)
                    2'd0: p.v = 8'(c);
                    2'd1: p.v = 8'(r);
                    2'd2: p.v = 8'h00;   // bit 3 of x and y is 0 throughout an 8x4 window
                    default: p.v = (r == 0 || r == VA - 1) ? 8'hFF : box_mid[c];
                endcase
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_frame_done", (fd_count >= n) ? 1 : 0, 1);
    endtask

    // Monitor: pops the scoreboard on every active pixel and checks line/frame shape.
    int cyc = 0, hs_run = 0, vs_run = 0, de_run = 0, de_lines = 0, fd_prev = 0;
    bit fd_prev_ok = 1'b0;
    pix_t e;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hs_run = 0; vs_run = 0; de_run = 0; de_lines = 0; fd_prev_ok = 1'b0;
        end else begin
            if (vif.ycbcr_hs) hs_run++;
            else if (hs_run > 0) begin check("hs_len", hs_run, HS); hs_run = 0; end

            if (vif.ycbcr_vs) vs_run++;
            else if (vs_run > 0) begin check("vs_len", vs_run, VS * 14); vs_run = 0; end

            if (vif.ycbcr_de) begin
                de_run++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel: de with no expected pixel at x=%0d y=%0d", vif.pix_x, vif.pix_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({vif.pix_x, vif.pix_y, vif.ycbcr_y} !== e) begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d luma=%02h expected x=%0d y=%0d luma=%02h",
                                 vif.pix_x, vif.pix_y, vif.ycbcr_y, e.x, e.y, e.v);
                    end
                end
            end else if (de_run > 0) begin
                check("de_len", de_run, HA);
                de_lines++;
                de_run = 0;
            end

            if (vif.frame_done) begin
                fd_count++;
                check("lines_per_frame", de_lines, VA);
                de_lines = 0;
                if (fd_prev_ok) check("frame_done_period", cyc - fd_prev, 98);
                fd_prev    = cyc;
                fd_prev_ok = 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        vif.enable      = 1'b0;
        vif.pattern_sel = 2'd0;
        rst_n           = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_hs",    vif.ycbcr_hs,   0);
        check("rst_vs",    vif.ycbcr_vs,   0);
        check("rst_de",    vif.ycbcr_de,   0);
        check("rst_y",     vif.ycbcr_y,    0);
        check("rst_pix_x", vif.pix_x,      0);
        check("rst_pix_y", vif.pix_y,      0);
        check("rst_fd",    vif.frame_done, 0);

        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hs", vif.ycbcr_hs, 0);
        check("idle_de", vif.ycbcr_de, 0);

        // Four back-to-back frames; each pattern change lands mid-frame.
        push_frame(2'd0);
        push_frame(2'd2);
        push_frame(2'd3);
        push_frame(2'd1);
        vif.pattern_sel = 2'd0;
        vif.enable      = 1'b1;
        repeat (40) @(negedge clk);
        vif.pattern_sel = 2'd2;
        wait_fd(1, 200);
        repeat (40) @(negedge clk);
        vif.pattern_sel = 2'd3;
        wait_fd(2, 200);
        repeat (40) @(negedge clk);
        vif.pattern_sel = 2'd1;
        wait_fd(3, 200);
        repeat (2 * 14 + 5) @(negedge clk);
        vif.enable = 1'b0;
        wait_fd(4, 200);
        repeat (200) @(negedge clk);
        check("fd_count_after_stop", fd_count, 4);
        check("queue_drained_stop",  exp_q.size(), 0);
        check("stop_hs", vif.ycbcr_hs, 0);
        check("stop_vs", vif.ycbcr_vs, 0);
        check("stop_de", vif.ycbcr_de, 0);

        // Reset during an active line.
        push_frame(2'd0);
        vif.pattern_sel = 2'd0;
        vif.enable      = 1'b1;
        k = 0;
        while (!vif.ycbcr_de && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("de_seen_before_reset", vif.ycbcr_de, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_de", vif.ycbcr_de,   0);
        check("async_rst_y",  vif.ycbcr_y,    0);
        check("async_rst_fd", vif.frame_done, 0);
        check("async_rst_hs", vif.ycbcr_hs,   0);
        repeat (3) @(negedge clk);
        push_frame(2'd0);
        rst_n = 1'b1;
        k = 0;
        while (!vif.ycbcr_hs && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("hs_start_latency", k, 2);
        check("first_hs_with_vs", vif.ycbcr_vs, 1);
        vif.enable = 1'b0;
        wait_fd(5, 200);
        repeat (50) @(negedge clk);
        check("fd_count_after_reset", fd_count, 5);
        check("queue_drained_reset",  exp_q.size(), 0);
        check("final_de", vif.ycbcr_de, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
